button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
// Front-end for the clock/alarm/stopwatch mode FSM. Synchronises and debounces
// three raw push-buttons, classifies INC presses as short or long, and emits
// single-cycle event pulses inc_short, inc_long, set, sw. At most one pulse is
// asserted in any cycle, matching the FSM's one-hot input decode.
// PARAMETERS
// DEBOUNCE_CYCLES  500000    consecutive stable cycles before a level change is accepted (10 ms @ 50 MHz)
// LONG_CYCLES      50000000  INC hold length, counted from debounced press, that makes a long press (1 s @ 50 MHz)
// CNT_W            localparam, $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES))+1
// PORTS
// clk          in   1  system clock
// rst          in   1  asynchronous, active-high reset
// btn_inc_raw  in   1  raw INC button, active-high, asynchronous to clk
// btn_set_raw  in   1  raw SET button, active-high, asynchronous to clk
// btn_sw_raw   in   1  raw stopwatch button, active-high, asynchronous to clk
// inc_short    out  1  1-cycle pulse: INC released before LONG_CYCLES
// inc_long     out  1  1-cycle pulse: INC held LONG_CYCLES
// set          out  1  1-cycle pulse: SET pressed
// sw           out  1  1-cycle pulse: stopwatch button pressed
// BEHAVIOUR
// - Reset: all flops, sync stages, debounced levels, counters, pending flags -> 0;
//   classifier -> IDLE; all four outputs 0 immediately (async) and while rst=1.
// - Sync: 2-FF synchroniser per button.
// - Debounce per button: counter increments each cycle synced != stable, clears
//   when equal; stable toggles and counter clears when counter hits DEBOUNCE_CYCLES-1.
//   Glitches shorter than DEBOUNCE_CYCLES synced cycles are discarded.
// - SET/SW: rising edge of stable level sets pend_set / pend_sw. Releases ignored.
// - INC classifier FSM (states IDLE, PRESSED, LONG_FIRED), hold_cnt saturating:
//   IDLE: stable rise -> PRESSED, hold_cnt=0.
//   PRESSED: hold_cnt++; stable fall -> pend_short, IDLE;
//            hold_cnt==LONG_CYCLES-1 while pressed -> pend_long, LONG_FIRED.
//   LONG_FIRED: stable fall -> IDLE, no event. Auto-repeat not supported.
// - Arbiter: each cycle emits the highest-priority set pending flag as a
//   registered 1-cycle pulse and clears that flag; priority set > sw > inc_long
//   > inc_short. Others stay pending and emit on following cycles (max 3 cycles
//   deferral, far below DEBOUNCE_CYCLES, so no event is lost or duplicated).
// - Latency: raw edge first sampled at edge N -> pulse high in cycle
//   N+DEBOUNCE_CYCLES+3 (uncontended). inc_short latency counted from release.
// - Button held across reset release: stable starts 0, so it is seen as a fresh
//   press after debounce. Reset mid-operation drops all pending events.
// - Exactly one output pulse per accepted press; never two outputs high together.
// STRUCTURE
// - Sub-module debounce_sync (2-FF sync + debounce counter, param DEBOUNCE_CYCLES,
//   outputs stable level and rise/fall strobes), instantiated 3x.
// - Classifier state encodings and output priority order go in the shared
//   clock-design defines header alongside the mode FSM state codes.
// - Top level holds classifier FSM, pending flags, arbiter, output registers.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
// 1. btn_set_raw high 3 cycles then low -> no pulse on any output.
// 2. btn_set_raw high 10 cycles, first sampled edge N -> set=1 only in cycle N+7, once.
// 3. btn_inc_raw high 12 cycles -> exactly one inc_short, 7 cycles after release
//    sampled; inc_long never asserted.
// 4. btn_inc_raw high 40 cycles -> exactly one inc_long ~20 cycles after debounced
//    press; no inc_short on release.
// 5. btn_set_raw and btn_sw_raw rise same cycle N -> set at N+7, sw at N+8, never overlapping.
// 6. rst asserted while INC held 15 cycles into press -> outputs 0 at once; no
//    inc_short/inc_long from old press; continued hold after release -> fresh press.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared clock-design codes (mode states, classifier states, event priority)
package button_event_decoder_pkg;
  typedef enum logic [1:0] {MODE_CLOCK, MODE_ALARM, MODE_STOPWATCH} mode_e;
  typedef enum logic [1:0] {CLS_IDLE, CLS_PRESSED, CLS_LONG_FIRED} cls_state_e;
  localparam int BTN_INC = 0;
  localparam int BTN_SET = 1;
  localparam int BTN_SW = 2;
  localparam int NUM_BTN = 3;
  // Lower event index wins arbitration: set > sw > inc_long > inc_short
  localparam int EV_SET = 0;
  localparam int EV_SW = 1;
  localparam int EV_LONG = 2;
  localparam int EV_SHORT = 3;
  localparam int NUM_EV = 4;
  typedef logic [NUM_EV-1:0] ev_t;
  typedef struct packed {
    logic stable;
    logic rise;
    logic fall;
  } btn_db_t;
  function automatic ev_t arb_pick(ev_t p);
    return p & -p;
  endfunction
endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: raw button inputs and decoded event pulses
interface button_event_decoder_if;
  logic btn_inc_raw;
  logic btn_set_raw;
  logic btn_sw_raw;
  logic inc_short;
  logic inc_long;
  logic set;
  logic sw;
  modport master (
    output btn_inc_raw, btn_set_raw, btn_sw_raw,
    input  inc_short, inc_long, set, sw
  );
  modport slave (
    input  btn_inc_raw, btn_set_raw, btn_sw_raw,
    output inc_short, inc_long, set, sw
  );
endinterface

// File: rtl/button_event_decoder_debounce_sync.sv
// debounce_sync: 2-FF synchroniser plus debounce counter with registered rise/fall strobes
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      stable <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        stable <= s2;
        rise <= s2;
        fall <= ~s2;
      end else cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: debounced buttons -> short/long INC, SET, SW one-hot event pulses
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES = 50000000
) (
  input logic clk,
  input logic rst,
  button_event_decoder_if.slave bus
);
  localparam int MAX_C = DEBOUNCE_CYCLES > LONG_CYCLES ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W = $clog2(MAX_C) + 1;
  logic [NUM_BTN-1:0] raw;
  btn_db_t db [NUM_BTN];
  cls_state_e state;
  logic [CNT_W-1:0] hold_cnt;
  ev_t pend, grant, req, ev;
  logic at_long;
  assign raw = {bus.btn_sw_raw, bus.btn_set_raw, bus.btn_inc_raw};
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(raw[i]),
      .stable(db[i].stable),
      .rise(db[i].rise),
      .fall(db[i].fall)
    );
  end
  assign at_long = state == CLS_PRESSED && hold_cnt == CNT_W'(LONG_CYCLES - 1);
  assign grant = arb_pick(pend);
  always_comb begin
    req = '0;
    req[EV_SET] = db[BTN_SET].rise;
    req[EV_SW] = db[BTN_SW].rise;
    req[EV_LONG] = at_long && !db[BTN_INC].fall;
    req[EV_SHORT] = state == CLS_PRESSED && db[BTN_INC].fall;
  end
  // Pending flags absorb simultaneous events; one is granted per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLS_IDLE;
      hold_cnt <= '0;
      pend <= '0;
      ev <= '0;
    end else begin
      ev <= grant;
      pend <= (pend & ~grant) | req;
      case (state)
        CLS_IDLE: if (db[BTN_INC].rise) begin
          state <= CLS_PRESSED;
          hold_cnt <= '0;
        end
        CLS_PRESSED:
          if (db[BTN_INC].fall) state <= CLS_IDLE;
          else if (at_long) state <= CLS_LONG_FIRED;
          else hold_cnt <= hold_cnt + CNT_W'(1);
        CLS_LONG_FIRED: if (!db[BTN_INC].stable) state <= CLS_IDLE;
        default: state <= CLS_IDLE;
      endcase
    end
  end
  assign bus.set = ev[EV_SET];
  assign bus.sw = ev[EV_SW];
  assign bus.inc_long = ev[EV_LONG];
  assign bus.inc_short = ev[EV_SHORT];
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed stimulus with a queue scoreboard and decoupled output monitor
module tb_button_event_decoder;
  typedef struct {
    logic [3:0] o;
    int c;
  } exp_t;
  localparam logic [3:0] O_SET = 4'b0001;
  localparam logic [3:0] O_SW = 4'b0010;
  localparam logic [3:0] O_LONG = 4'b0100;
  localparam logic [3:0] O_SHORT = 4'b1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] raw = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  button_event_decoder_if bus ();
  assign bus.btn_inc_raw = raw[0];
  assign bus.btn_set_raw = raw[1];
  assign bus.btn_sw_raw = raw[2];
  button_event_decoder #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [3:0] outs();
    return {bus.inc_short, bus.inc_long, bus.sw, bus.set};
  endfunction
  always @(posedge clk) begin
    logic [3:0] o;
    exp_t e;
    #1;
    o = outs();
    if (rst) begin
      total++;
      if (o !== 4'b0) begin
        bad++;
        $display("FAIL rst_quiet cyc=%0d got=%b want=0000", cyc, o);
      end
    end else if (o !== 4'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, o);
      end else begin
        e = q.pop_front();
        if (o !== e.o || cyc != e.c) begin
          bad++;
          $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", cyc, o, e.o, e.c);
        end
      end
    end
  end
  task automatic expect_ev(input logic [3:0] o, input int c);
    exp_t e;
    e.o = o;
    e.c = c;
    q.push_back(e);
  endtask
  task automatic go(input logic [2:0] m, output int n);
    @(posedge clk);
    #2;
    raw = m;
    n = cyc + 1;
  endtask
  task automatic rel(input int k);
    repeat (k) @(posedge clk);
    #2;
    raw = '0;
  endtask
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
  endtask
  task automatic check_async_quiet(input string name);
    #1;
    total++;
    if (outs() !== 4'b0) begin
      bad++;
      $display("FAIL %s got=%b want=0000", name, outs());
    end
  endtask
  initial begin
    int n, m;
    idle(3);
    #2;
    rst = 1'b0;
    idle(5);
    // 1: 3-cycle SET glitch is filtered
    go(3'b010, n);
    rel(3);
    idle(25);
    // 2: SET 10 cycles -> set at n+7; async reset right after the pulse
    go(3'b010, n);
    expect_ev(O_SET, n + 7);
    idle(8);
    #2;
    rst = 1'b1;
    check_async_quiet("async_rst_set");
    @(posedge clk);
    #2;
    rst = 1'b0;
    rel(1);
    idle(25);
    // 3: INC 12 cycles -> inc_short 7 cycles after release sampled
    go(3'b001, n);
    expect_ev(O_SHORT, n + 19);
    rel(12);
    idle(25);
    // 4: INC 40 cycles -> inc_long only
    go(3'b001, n);
    expect_ev(O_LONG, n + 27);
    rel(40);
    idle(25);
    // 5: SET and SW together -> set then sw on consecutive cycles
    go(3'b110, n);
    expect_ev(O_SET, n + 7);
    expect_ev(O_SW, n + 8);
    rel(10);
    idle(25);
    // 6: reset mid INC press, continued hold is a fresh short press
    go(3'b001, n);
    idle(15);
    #2;
    rst = 1'b1;
    check_async_quiet("async_rst_inc");
    idle(3);
    #2;
    rst = 1'b0;
    m = cyc + 1;
    expect_ev(O_SHORT, m + 19);
    rel(12);
    idle(40);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
